sorted_block_store: RTL and testbench
=====================================

# sorted_block_store

Storage and writer stage that consumes the result of a one-block index finder (value, id, flag, signed global index) and physically inserts the value into a DEPTH-entry ascending sorted register array. Entries pushed past the top of a full block go out on an overflow port to the next block, and a drain command streams the block contents out in ascending order. One instance per BLOCK sits directly behind that block's index finder.

## Interface
- WIDTH, 16, data width of stored values
- DEPTH, 10, entries per block
- BLOCK, 0, block number; global index base LOW = BLOCK*DEPTH
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  insert request valid
- in_ready  out  1  store can accept an insert this cycle
- in_data  in  WIDTH  value to insert
- in_id  in  4  tag carried with value
- in_flag  in  2  finder flag: init=00, less=01, fit=10, larger=11
- in_index  in  8 signed  global insertion index from finder
- ovf_valid / ovf_ready  out / in  1 / 1  evicted-entry handshake
- ovf_data / ovf_id  out  WIDTH / 4  evicted value and tag
- drain_req  in  1  single-cycle request to stream contents out
- out_valid / out_ready  out / in  1 / 1  drain stream handshake
- out_data / out_id / out_last  out  WIDTH / 4 / 1  drained entry; last marks final entry
- drain_done  out  1  one-cycle pulse when a drain completes
- miss  out  1  one-cycle pulse: accepted insert had flag != fit and was not stored
- count  out  4  valid entries, 0..DEPTH

## Operation
- FSM states: IDLE, OVF_HOLD, DRAIN.
- in_ready = (state==IDLE) && !drain_req. drain_req in IDLE wins over in_valid.
- Accept (in_valid && in_ready):
  - flag != fit: no storage change; miss pulses next cycle.
  - flag == fit: local position p = in_index - LOW.
  - Clamp p<0 to 0. in_index==100 is the append sentinel: p = count. Any p>count becomes count.
  - Entries [p..count-1] shift up one slot, and the new entry is written at p.
  - If count<DEPTH, count increments.
  - If count==DEPTH and p<DEPTH, the entry previously at DEPTH-1 is evicted.
  - If count==DEPTH and p==DEPTH, the incoming entry itself is evicted and the array is unchanged.
  - On eviction, the evicted entry is registered onto ovf_* and the FSM goes to OVF_HOLD.
- OVF_HOLD: ovf_valid held with stable data until ovf_ready, then IDLE.
- DRAIN (from IDLE on drain_req):
  - Presents entries 0..count-1 in order. Each advances on out_valid && out_ready.
  - out_last is set on entry count-1.
  - After the last transfer: count cleared, drain_done pulses, FSM returns to IDLE.
  - Drain with count==0: no out_valid; drain_done pulses the next cycle; FSM back to IDLE.
- Array order invariant: entry[i] <= entry[i+1] for i<count-1, given correct finder indices.
- Ties: equal values keep arrival order. The finder index places the new entry after equals.

## Timing
- Reset: state IDLE, count 0, array contents don't-care. All valid/pulse outputs are 0, and ovf_data/ovf_id/out_data/out_id are 0.
- Insert latency 1 cycle: array and count update on the accepting edge; ovf_valid and miss assert the following cycle.
- Back-to-back inserts at one per cycle with no eviction.
- An eviction blocks in_ready until the ovf handshake completes; the minimum is 1 stall cycle.
- Drain throughput 1 entry/cycle. out_data is a registered read of the drain pointer.
- The drain pointer is 4 bits, counts 0..count-1, and never wraps.
- rst mid-drain or mid-OVF_HOLD: abort immediately. No further out_valid/ovf_valid and no drain_done.
- drain_req outside IDLE is ignored and not queued.

## Structure
- Shared package sort_pkg:
  - flag localparams init/less/fit/larger
  - sentinel index 100
  - state enum {IDLE, OVF_HOLD, DRAIN}
  - these are shared with the finder-side blocks
- One sub-module, insert_pos_calc: combinational computation of p (clamp, sentinel, p>count rule) and the evict-incoming decision.
- Shift/insert array, FSM and drain pointer stay in the top module.

## Test plan
- Empty, BLOCK=0, insert fit values 30, 10, 20 with indices 0, 0, 1 → drain outputs 10, 20, 30; out_last on 30; count 0 after; drain_done once.
- Fill to DEPTH=10 with 0..90 step 10, insert 45 at index 5 → ovf_data=90 exactly one cycle later; in_ready low until ovf_ready.
- Full block, insert 95 with index 100 → ovf_data=95 and array unchanged; insert 5 at index -1 → stored at entry 0 and 90 evicted.
- in_flag=less (01) with in_valid → miss pulses, count unchanged. BLOCK=2 with in_index 23 → stored at local slot 3.
- drain_req and in_valid in the same cycle → in_ready=0, drain starts, insert not accepted. drain_req with count 0 → drain_done next cycle, no out_valid.
- rst asserted on the second drain beat with out_ready held low → all outputs 0 next cycle, count 0, no drain_done.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the sorted-block pipeline: finder flag codes, the
// append sentinel index, and the store FSM state encoding.
package sort_pkg;

  localparam logic [1:0] FLAG_INIT   = 2'b00;
  localparam logic [1:0] FLAG_LESS   = 2'b01;
  localparam logic [1:0] FLAG_FIT    = 2'b10;
  localparam logic [1:0] FLAG_LARGER = 2'b11;

  localparam int SENTINEL_IDX = 100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OVF_HOLD = 2'd1,
    DRAIN    = 2'd2
  } state_e;

endpackage

// File: rtl/insert_pos_calc.sv
// Maps the finder's global index onto a local slot in 0..count and flags the
// case where the incoming value itself falls off the top of a full block.
module insert_pos_calc
  import sort_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int BLOCK = 0
) (
  input  logic signed [7:0] in_index,
  input  logic [3:0]        count,
  output logic [3:0]        pos,
  output logic              evict_incoming
);

  localparam int LOW = BLOCK * DEPTH;

  logic signed [15:0] rel;

  always_comb begin
    rel = 16'(in_index) - 16'(LOW);
    pos = rel[3:0];
    if (in_index == 8'(SENTINEL_IDX)) begin
      pos = count;
    end else if (rel < 16'sd0) begin
      pos = 4'd0;
    end else if (rel > $signed({12'd0, count})) begin
      pos = count;
    end
    // pos never exceeds count, so pos==DEPTH implies the block is full
    evict_incoming = (count == 4'(DEPTH)) && (pos == 4'(DEPTH));
  end

endmodule

// File: rtl/sorted_block_store.sv
// One block of a sorted register store: inserts finder results in place,
// spills the top entry to the next block when full, and drains in order.
module sorted_block_store
  import sort_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10,
  parameter int BLOCK = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [3:0]        in_id,
  input  logic [1:0]        in_flag,
  input  logic signed [7:0] in_index,
  output logic              ovf_valid,
  input  logic              ovf_ready,
  output logic [WIDTH-1:0]  ovf_data,
  output logic [3:0]        ovf_id,
  input  logic              drain_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [3:0]        out_id,
  output logic              out_last,
  output logic              drain_done,
  output logic              miss,
  output logic [3:0]        count
);

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [3:0]       id_q [DEPTH];
  logic [3:0]       id_d [DEPTH];
  logic [WIDTH-1:0] ovf_data_q, ovf_data_d;
  logic [3:0]       ovf_id_q, ovf_id_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]       out_id_q, out_id_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             miss_q, miss_d;
  logic             done_q, done_d;

  logic [3:0]       pos;
  logic             evict_incoming;
  logic [3:0]       nxt_ptr;

  insert_pos_calc #(
    .DEPTH (DEPTH),
    .BLOCK (BLOCK)
  ) u_pos (
    .in_index       (in_index),
    .count          (count_q),
    .pos            (pos),
    .evict_incoming (evict_incoming)
  );

  assign nxt_ptr = ptr_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    id_d        = id_q;
    ovf_data_d  = ovf_data_q;
    ovf_id_d    = ovf_id_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    miss_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (drain_req) begin
          if (count_q == 4'd0) begin
            done_d = 1'b1;
          end else begin
            state_d     = DRAIN;
            ptr_d       = 4'd0;
            out_valid_d = 1'b1;
            out_data_d  = data_q[0];
            out_id_d    = id_q[0];
            out_last_d  = (count_q == 4'd1);
          end
        end else if (in_valid) begin
          if (in_flag != FLAG_FIT) begin
            miss_d = 1'b1;
          end else if (evict_incoming) begin
            ovf_data_d = in_data;
            ovf_id_d   = in_id;
            state_d    = OVF_HOLD;
          end else begin
            // Open a hole at pos by moving [pos..count-1] up one slot
            for (int i = 1; i < DEPTH; i++) begin
              if ((i > int'(pos)) && (i <= int'(count_q))) begin
                data_d[i] = data_q[i-1];
                id_d[i]   = id_q[i-1];
              end
            end
            data_d[pos] = in_data;
            id_d[pos]   = in_id;
            if (count_q == 4'(DEPTH)) begin
              ovf_data_d = data_q[DEPTH-1];
              ovf_id_d   = id_q[DEPTH-1];
              state_d    = OVF_HOLD;
            end else begin
              count_d = count_q + 4'd1;
            end
          end
        end
      end

      OVF_HOLD: begin
        if (ovf_ready) begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            count_d     = 4'd0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            ptr_d      = nxt_ptr;
            out_data_d = data_q[nxt_ptr];
            out_id_d   = id_q[nxt_ptr];
            out_last_d = (nxt_ptr == (count_q - 4'd1));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      ptr_q       <= 4'd0;
      ovf_data_q  <= '0;
      ovf_id_q    <= 4'd0;
      out_data_q  <= '0;
      out_id_q    <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      miss_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      ovf_data_q  <= ovf_data_d;
      ovf_id_q    <= ovf_id_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      miss_q      <= miss_d;
      done_q      <= done_d;
    end
  end

  // Array contents are meaningful only below count, so they skip reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
    id_q   <= id_d;
  end

  assign in_ready   = (state_q == IDLE) && !drain_req;
  assign ovf_valid  = (state_q == OVF_HOLD);
  assign ovf_data   = ovf_data_q;
  assign ovf_id     = ovf_id_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign out_last   = out_last_q;
  assign drain_done = done_q;
  assign miss       = miss_q;
  assign count      = count_q;

endmodule

// File: tb/tb_sorted_block_store.sv
// Bench for sorted_block_store: directed table, randomized inserts/drains
// against a queue model, and hand sequences for reset, collision and BLOCK=2.
module tb_sorted_block_store;
  import sort_pkg::*;

  localparam int DEPTH = 10;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  id;
  } ent_t;

  typedef struct {
    int          op;
    logic [15:0] d;
    logic [3:0]  id;
    logic [1:0]  fl;
    int          idx;
    int          exp_count;
    bit          exp_ovf;
    logic [15:0] exp_ovf_d;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, ovf_valid, ovf_ready, drain_req;
  logic              out_valid, out_ready, out_last, drain_done, miss;
  logic [15:0]       in_data, ovf_data, out_data;
  logic [3:0]        in_id, ovf_id, out_id, count;
  logic [1:0]        in_flag;
  logic signed [7:0] in_index;

  logic              in_valid2, in_ready2, ovf_valid2, ovf_ready2, drain_req2;
  logic              out_valid2, out_ready2, out_last2, drain_done2, miss2;
  logic [15:0]       in_data2, ovf_data2, out_data2;
  logic [3:0]        in_id2, ovf_id2, out_id2, count2;
  logic [1:0]        in_flag2;
  logic signed [7:0] in_index2;

  sorted_block_store #(.WIDTH(16), .DEPTH(DEPTH), .BLOCK(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_id(in_id), .in_flag(in_flag), .in_index(in_index),
    .ovf_valid(ovf_valid), .ovf_ready(ovf_ready), .ovf_data(ovf_data), .ovf_id(ovf_id),
    .drain_req(drain_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .drain_done(drain_done), .miss(miss), .count(count)
  );

  sorted_block_store #(.WIDTH(16), .DEPTH(DEPTH), .BLOCK(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_id(in_id2), .in_flag(in_flag2), .in_index(in_index2),
    .ovf_valid(ovf_valid2), .ovf_ready(ovf_ready2), .ovf_data(ovf_data2), .ovf_id(ovf_id2),
    .drain_req(drain_req2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_id(out_id2), .out_last(out_last2),
    .drain_done(drain_done2), .miss(miss2), .count(count2)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  vec_t vecs[32];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [15:0] d, input logic [3:0] id,
                              input logic [1:0] fl, input int idx, input int ec,
                              input bit eo, input logic [15:0] eod);
    vec_t v;
    v.op = op; v.d = d; v.id = id; v.fl = fl; v.idx = idx;
    v.exp_count = ec; v.exp_ovf = eo; v.exp_ovf_d = eod;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nv] = v;
    nv++;
  endtask

  task automatic ovf_ack(input int stall, input ent_t ev);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("ovf_hold_valid", 32'(ovf_valid), 32'd1);
      chk("ovf_hold_data", 32'(ovf_data), 32'(ev.d));
      chk("ovf_hold_in_ready", 32'(in_ready), 32'd0);
    end
    ovf_ready = 1'b1;
    @(posedge clk); #1;
    ovf_ready = 1'b0;
    chk("ovf_release_valid", 32'(ovf_valid), 32'd0);
    chk("ovf_release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Model: block 0 is a list; insert at the clamped position, spill the tail past DEPTH
  task automatic insert(input logic [15:0] d, input logic [3:0] id, input logic [1:0] fl,
                        input int idx, input int stall, output logic ov, output logic [15:0] od);
    int   n;
    int   p;
    bit   exp_ev;
    ent_t ev;
    ent_t e;
    n = 0;
    exp_ev = 1'b0;
    in_valid = 1'b1; in_data = d; in_id = id; in_flag = fl; in_index = 8'(idx);
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 32'(n < 40), 32'd1);
    if (fl == FLAG_FIT) begin
      p = (idx == SENTINEL_IDX) ? mq.size() : idx;
      if (p < 0) p = 0;
      if (p > mq.size()) p = mq.size();
      e.d = d; e.id = id;
      mq.insert(p, e);
      if (mq.size() > DEPTH) begin
        exp_ev = 1'b1;
        ev = mq.pop_back();
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ov = ovf_valid;
    od = ovf_data;
    chk("miss", 32'(miss), 32'(fl != FLAG_FIT));
    chk("ovf_valid", 32'(ovf_valid), 32'(exp_ev));
    chk("count", 32'(count), 32'(mq.size()));
    if (exp_ev) begin
      chk("ovf_data", 32'(ovf_data), 32'(ev.d));
      chk("ovf_id", 32'(ovf_id), 32'(ev.id));
      chk("ovf_in_ready", 32'(in_ready), 32'd0);
      ovf_ack(stall, ev);
    end
  endtask

  task automatic drain(input bit with_insert);
    int n;
    int w;
    n = mq.size();
    drain_req = 1'b1;
    if (with_insert) begin
      in_valid = 1'b1; in_data = 16'hBEEF; in_id = 4'hE; in_flag = FLAG_FIT; in_index = 8'sd0;
    end
    #1;
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    drain_req = 1'b0;
    in_valid = 1'b0;
    if (n == 0) begin
      chk("empty_drain_done", 32'(drain_done), 32'd1);
      chk("empty_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("empty_done_once", 32'(drain_done), 32'd0);
      chk("empty_out_valid2", 32'(out_valid), 32'd0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        out_ready = (w > 4) ? 1'b1 : 1'($urandom_range(0, 1));
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_data", 32'(out_data), 32'(mq[k].d));
        chk("out_id", 32'(out_id), 32'(mq[k].id));
        chk("out_last", 32'(out_last), 32'(k == n - 1));
        chk("drain_done_early", 32'(drain_done), 32'd0);
        @(posedge clk); #1;
        w++;
      end while (!out_ready);
    end
    out_ready = 1'b0;
    chk("drain_done", 32'(drain_done), 32'd1);
    chk("drain_out_valid_end", 32'(out_valid), 32'd0);
    chk("drain_count_zero", 32'(count), 32'd0);
    mq.delete();
    @(posedge clk); #1;
    chk("drain_done_once", 32'(drain_done), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ov;
    logic [15:0] od;
    logic [15:0] exp2 [6];

    in_valid = 0; in_data = 0; in_id = 0; in_flag = 0; in_index = 0;
    ovf_ready = 0; drain_req = 0; out_ready = 0;
    in_valid2 = 0; in_data2 = 0; in_id2 = 0; in_flag2 = 0; in_index2 = 0;
    ovf_ready2 = 0; drain_req2 = 0; out_ready2 = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf_valid", 32'(ovf_valid), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_drain_done", 32'(drain_done), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_ovf_data", 32'(ovf_data), 32'd0);
    chk("rst_ovf_id", 32'(ovf_id), 32'd0);
    chk("rst_count2", 32'(count2), 32'd0);

    // Directed table: small sort, full-block evictions, sentinel, clamp, miss, empty drain
    add(mk(0, 16'd30, 4'd1, FLAG_FIT, 0, 1, 0, 0));
    add(mk(0, 16'd10, 4'd2, FLAG_FIT, 0, 2, 0, 0));
    add(mk(0, 16'd20, 4'd3, FLAG_FIT, 1, 3, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) add(mk(0, 16'(10 * i), 4'(i), FLAG_FIT, i, i + 1, 0, 0));
    add(mk(0, 16'd45, 4'd11, FLAG_FIT, 5, 10, 1, 16'd90));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) add(mk(0, 16'(10 * i), 4'(i), FLAG_FIT, i, i + 1, 0, 0));
    add(mk(0, 16'd95, 4'd12, FLAG_FIT, 100, 10, 1, 16'd95));
    add(mk(0, 16'd5, 4'd13, FLAG_FIT, -1, 10, 1, 16'd90));
    add(mk(0, 16'd7, 4'd14, FLAG_LESS, 3, 10, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < nv; i++) begin
      if (vecs[i].op == 1) begin
        drain(1'b0);
      end else begin
        insert(vecs[i].d, vecs[i].id, vecs[i].fl, vecs[i].idx, i % 3, ov, od);
        chk("tbl_count", 32'(count), 32'(vecs[i].exp_count));
        chk("tbl_ovf", 32'(ov), 32'(vecs[i].exp_ovf));
        if (vecs[i].exp_ovf) chk("tbl_ovf_data", 32'(od), 32'(vecs[i].exp_ovf_d));
      end
    end

    // BLOCK=2: global index 23 lands in local slot 3; index 40 clamps to the end
    exp2[0] = 16'd1; exp2[1] = 16'd2; exp2[2] = 16'd3;
    exp2[3] = 16'd50; exp2[4] = 16'd4; exp2[5] = 16'd60;
    in_flag2 = FLAG_FIT;
    for (int i = 0; i < 6; i++) begin
      in_valid2 = 1'b1;
      in_data2  = (i < 4) ? 16'(i + 1) : ((i == 4) ? 16'd50 : 16'd60);
      in_id2    = 4'(i);
      in_index2 = (i < 4) ? 8'(20 + i) : ((i == 4) ? 8'sd23 : 8'sd40);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    chk("b2_count", 32'(count2), 32'd6);
    drain_req2 = 1'b1;
    @(posedge clk); #1;
    drain_req2 = 1'b0;
    out_ready2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("b2_out_valid", 32'(out_valid2), 32'd1);
      chk("b2_out_data", 32'(out_data2), 32'(exp2[k]));
      @(posedge clk); #1;
    end
    out_ready2 = 1'b0;
    chk("b2_drain_done", 32'(drain_done2), 32'd1);

    // Randomized traffic against the list model
    for (int it = 0; it < 400; it++) begin
      int r;
      int idx;
      logic [1:0] fl;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        drain(1'b0);
      end else begin
        fl  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : FLAG_FIT;
        idx = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 15)) - 3;
        insert(16'($urandom_range(0, 200)), 4'($urandom_range(0, 15)), fl, idx,
               int'($urandom_range(0, 3)), ov, od);
      end
    end
    drain(1'b0);

    // drain_req collides with in_valid: drain wins, insert is dropped
    insert(16'd11, 4'd1, FLAG_FIT, 100, 0, ov, od);
    insert(16'd22, 4'd2, FLAG_FIT, 100, 0, ov, od);
    drain(1'b1);

    // Reset while the second beat is presented with out_ready low
    insert(16'd3, 4'd3, FLAG_FIT, 100, 0, ov, od);
    insert(16'd6, 4'd6, FLAG_FIT, 100, 0, ov, od);
    insert(16'd9, 4'd9, FLAG_FIT, 100, 0, ov, od);
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("mid_second_beat", 32'(out_data), 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_out_id", 32'(out_id), 32'd0);
    chk("abort_out_last", 32'(out_last), 32'd0);
    chk("abort_drain_done", 32'(drain_done), 32'd0);
    chk("abort_ovf_valid", 32'(ovf_valid), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(drain_done), 32'd0);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
